scr1_axi_mem_arb: RTL and testbench

Round-robin AXI4 arbiter that shares one single-beat AXI slave port, such as the testbench AXI memory, between N_M requesting masters, for example the core IMEM/DMEM ports plus an accelerator port. Read and write paths are independent. Each path has its own round-robin pointer and its own FSM, and allows one outstanding transaction. The block sits between the master-side interconnect and the memory slave. Responses are routed back to the master that was granted.

---
 rtl/scr1_axi_mem_arb.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_scr1_axi_mem_arb.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/scr1_axi_mem_arb.sv
// Round-robin arbiter sharing one single-beat AXI4 slave between N_M masters.
// Read and write paths are independent, each with its own pointer, FSM and one outstanding transaction.
module scr1_axi_mem_arb #(
    parameter int N_M    = 2,
    parameter int W_ID   = 4,
    parameter int W_ADR  = 32,
    parameter int W_DATA = 32
) (
    input  logic                              clk,
    input  logic                              rst_n,
    // master read-address / read-data
    input  logic [N_M-1:0]                    m_arvalid,
    output logic [N_M-1:0]                    m_arready,
    input  logic [N_M-1:0][W_ID-1:0]          m_arid,
    input  logic [N_M-1:0][W_ADR-1:0]         m_araddr,
    input  logic [N_M-1:0][2:0]               m_arsize,
    output logic [N_M-1:0]                    m_rvalid,
    input  logic [N_M-1:0]                    m_rready,
    output logic [N_M-1:0][W_ID-1:0]          m_rid,
    output logic [N_M-1:0][W_DATA-1:0]        m_rdata,
    output logic [N_M-1:0][1:0]               m_rresp,
    output logic [N_M-1:0]                    m_rlast,
    // master write-address / write-data / write-response
    input  logic [N_M-1:0]                    m_awvalid,
    output logic [N_M-1:0]                    m_awready,
    input  logic [N_M-1:0][W_ID-1:0]          m_awid,
    input  logic [N_M-1:0][W_ADR-1:0]         m_awaddr,
    input  logic [N_M-1:0][2:0]               m_awsize,
    input  logic [N_M-1:0]                    m_wvalid,
    output logic [N_M-1:0]                    m_wready,
    input  logic [N_M-1:0][W_DATA-1:0]        m_wdata,
    input  logic [N_M-1:0][W_DATA/8-1:0]      m_wstrb,
    output logic [N_M-1:0]                    m_bvalid,
    input  logic [N_M-1:0]                    m_bready,
    output logic [N_M-1:0][W_ID-1:0]          m_bid,
    output logic [N_M-1:0][1:0]               m_bresp,
    // slave read channels
    output logic                              s_arvalid,
    input  logic                              s_arready,
    output logic [W_ID-1:0]                   s_arid,
    output logic [W_ADR-1:0]                  s_araddr,
    output logic [2:0]                        s_arsize,
    output logic [7:0]                        s_arlen,
    output logic [1:0]                        s_arburst,
    input  logic                              s_rvalid,
    output logic                              s_rready,
    input  logic [W_ID-1:0]                   s_rid,
    input  logic [W_DATA-1:0]                 s_rdata,
    input  logic [1:0]                        s_rresp,
    input  logic                              s_rlast,
    // slave write channels
    output logic                              s_awvalid,
    input  logic                              s_awready,
    output logic [W_ID-1:0]                   s_awid,
    output logic [W_ADR-1:0]                  s_awaddr,
    output logic [2:0]                        s_awsize,
    output logic [7:0]                        s_awlen,
    output logic                              s_wvalid,
    input  logic                              s_wready,
    output logic [W_DATA-1:0]                 s_wdata,
    output logic [W_DATA/8-1:0]               s_wstrb,
    output logic                              s_wlast,
    input  logic                              s_bvalid,
    output logic                              s_bready,
    input  logic [W_ID-1:0]                   s_bid,
    input  logic [1:0]                        s_bresp
);

    localparam int W_PTR = (N_M > 1) ? $clog2(N_M) : 1;

    typedef enum logic [1:0] {R_IDLE = 2'd0, R_ADDR = 2'd1, R_DATA = 2'd2} r_state_t;
    typedef enum logic [1:0] {W_IDLE = 2'd0, W_XFER = 2'd1, W_RESP = 2'd2} w_state_t;

    // First requester found scanning upward from ptr, wrapping modulo N_M.
    function automatic logic [W_PTR-1:0] rr_pick(input logic [N_M-1:0] req, input logic [W_PTR-1:0] ptr);
        logic [W_PTR-1:0] win;
        logic [W_PTR:0]   sum;
        logic             found;
        win   = ptr;
        found = 1'b0;
        for (int i = 0; i < N_M; i++) begin
            sum = {1'b0, ptr} + (W_PTR+1)'(i);
            if (sum >= (W_PTR+1)'(N_M)) begin
                sum = sum - (W_PTR+1)'(N_M);
            end else begin
                sum = sum;
            end
            if (!found && req[sum[W_PTR-1:0]]) begin
                win   = sum[W_PTR-1:0];
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return win;
    endfunction

    function automatic logic [W_PTR-1:0] ptr_inc(input logic [W_PTR-1:0] g);
        if (g == W_PTR'(N_M-1)) begin
            return '0;
        end else begin
            return g + W_PTR'(1);
        end
    endfunction

    assign s_arlen   = 8'd0;
    assign s_arburst = 2'b01;
    assign s_awlen   = 8'd0;
    assign s_wlast   = 1'b1;

    r_state_t         r_state_r, r_state_nxt_s;
    logic [W_PTR-1:0] r_ptr_r, r_gnt_r, r_win_s;
    logic             r_accept_s, r_done_s;

    // Read path: arbitration, slave address phase and granted-lane data routing.
    always_comb begin
        r_state_nxt_s = r_state_r;
        r_win_s       = rr_pick(m_arvalid, r_ptr_r);
        r_accept_s    = 1'b0;
        r_done_s      = 1'b0;
        m_arready     = '0;
        s_arvalid     = 1'b0;
        s_rready      = 1'b0;
        m_rvalid      = '0;
        m_rid         = '0;
        m_rdata       = '0;
        m_rresp       = '0;
        m_rlast       = '0;
        case (r_state_r)
            R_IDLE: begin
                if (|m_arvalid) begin
                    // Gated by rst_n so no ready escapes while reset is held.
                    m_arready[r_win_s] = rst_n;
                    r_accept_s         = 1'b1;
                    r_state_nxt_s      = R_ADDR;
                end else begin
                    r_state_nxt_s = R_IDLE;
                end
            end
            R_ADDR: begin
                s_arvalid = 1'b1;
                if (s_arready) begin
                    r_state_nxt_s = R_DATA;
                end else begin
                    r_state_nxt_s = R_ADDR;
                end
            end
            R_DATA: begin
                m_rvalid[r_gnt_r] = s_rvalid;
                m_rid[r_gnt_r]    = s_rid;
                m_rdata[r_gnt_r]  = s_rdata;
                m_rresp[r_gnt_r]  = s_rresp;
                m_rlast[r_gnt_r]  = s_rlast;
                s_rready          = m_rready[r_gnt_r];
                if (s_rvalid && m_rready[r_gnt_r]) begin
                    r_done_s      = 1'b1;
                    r_state_nxt_s = R_IDLE;
                end else begin
                    r_state_nxt_s = R_DATA;
                end
            end
            default: begin
                r_state_nxt_s = R_IDLE;
            end
        endcase
    end

    // Read path state, grant, pointer and captured address payload.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_r <= R_IDLE;
            r_ptr_r   <= '0;
            r_gnt_r   <= '0;
            s_arid    <= '0;
            s_araddr  <= '0;
            s_arsize  <= 3'd0;
        end else begin
            r_state_r <= r_state_nxt_s;
            if (r_accept_s) begin
                r_gnt_r  <= r_win_s;
                s_arid   <= m_arid[r_win_s];
                s_araddr <= m_araddr[r_win_s];
                s_arsize <= m_arsize[r_win_s];
            end
            if (r_done_s) begin
                r_ptr_r <= ptr_inc(r_gnt_r);
            end
        end
    end

    w_state_t         w_state_r, w_state_nxt_s;
    logic [W_PTR-1:0] w_ptr_r, w_gnt_r, w_win_s;
    logic             w_accept_s, w_finish_s;
    logic             aw_done_r, w_done_r, aw_done_nxt_s, w_done_nxt_s;

    // Write path: arbitration, address/data in either order, then response routing.
    always_comb begin
        w_state_nxt_s = w_state_r;
        w_win_s       = rr_pick(m_awvalid, w_ptr_r);
        w_accept_s    = 1'b0;
        w_finish_s    = 1'b0;
        aw_done_nxt_s = aw_done_r;
        w_done_nxt_s  = w_done_r;
        m_awready     = '0;
        m_wready      = '0;
        m_bvalid      = '0;
        m_bid         = '0;
        m_bresp       = '0;
        s_awvalid     = 1'b0;
        s_wvalid      = 1'b0;
        s_wdata       = '0;
        s_wstrb       = '0;
        s_bready      = 1'b0;
        case (w_state_r)
            W_IDLE: begin
                if (|m_awvalid) begin
                    m_awready[w_win_s] = rst_n;
                    w_accept_s         = 1'b1;
                    aw_done_nxt_s      = 1'b0;
                    w_done_nxt_s       = 1'b0;
                    w_state_nxt_s      = W_XFER;
                end else begin
                    w_state_nxt_s = W_IDLE;
                end
            end
            W_XFER: begin
                s_awvalid         = !aw_done_r;
                s_wvalid          = m_wvalid[w_gnt_r] & !w_done_r;
                s_wdata           = m_wdata[w_gnt_r];
                s_wstrb           = m_wstrb[w_gnt_r];
                m_wready[w_gnt_r] = s_wready & !w_done_r;
                aw_done_nxt_s     = aw_done_r | s_awready;
                w_done_nxt_s      = w_done_r | (m_wvalid[w_gnt_r] & s_wready);
                if (aw_done_nxt_s && w_done_nxt_s) begin
                    w_state_nxt_s = W_RESP;
                end else begin
                    w_state_nxt_s = W_XFER;
                end
            end
            W_RESP: begin
                m_bvalid[w_gnt_r] = s_bvalid;
                m_bid[w_gnt_r]    = s_bid;
                m_bresp[w_gnt_r]  = s_bresp;
                s_bready          = m_bready[w_gnt_r];
                if (s_bvalid && m_bready[w_gnt_r]) begin
                    w_finish_s    = 1'b1;
                    w_state_nxt_s = W_IDLE;
                end else begin
                    w_state_nxt_s = W_RESP;
                end
            end
            default: begin
                w_state_nxt_s = W_IDLE;
            end
        endcase
    end

    // Write path state, channel-done flags, grant, pointer and captured address payload.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state_r <= W_IDLE;
            w_ptr_r   <= '0;
            w_gnt_r   <= '0;
            aw_done_r <= 1'b0;
            w_done_r  <= 1'b0;
            s_awid    <= '0;
            s_awaddr  <= '0;
            s_awsize  <= 3'd0;
        end else begin
            w_state_r <= w_state_nxt_s;
            aw_done_r <= aw_done_nxt_s;
            w_done_r  <= w_done_nxt_s;
            if (w_accept_s) begin
                w_gnt_r  <= w_win_s;
                s_awid   <= m_awid[w_win_s];
                s_awaddr <= m_awaddr[w_win_s];
                s_awsize <= m_awsize[w_win_s];
            end
            if (w_finish_s) begin
                w_ptr_r <= ptr_inc(w_gnt_r);
            end
        end
    end

endmodule

// File: tb/tb_scr1_axi_mem_arb.sv
// Directed bench for scr1_axi_mem_arb with two masters; slave and masters are driven by hand.
module tb_scr1_axi_mem_arb;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [1:0]        m_arvalid = '0, m_arready;
    logic [1:0][3:0]   m_arid = '0;
    logic [1:0][31:0]  m_araddr = '0;
    logic [1:0][2:0]   m_arsize = '0;
    logic [1:0]        m_rvalid, m_rready = '0;
    logic [1:0][3:0]   m_rid;
    logic [1:0][31:0]  m_rdata;
    logic [1:0][1:0]   m_rresp;
    logic [1:0]        m_rlast;
    logic [1:0]        m_awvalid = '0, m_awready;
    logic [1:0][3:0]   m_awid = '0;
    logic [1:0][31:0]  m_awaddr = '0;
    logic [1:0][2:0]   m_awsize = '0;
    logic [1:0]        m_wvalid = '0, m_wready;
    logic [1:0][31:0]  m_wdata = '0;
    logic [1:0][3:0]   m_wstrb = '0;
    logic [1:0]        m_bvalid, m_bready = '0;
    logic [1:0][3:0]   m_bid;
    logic [1:0][1:0]   m_bresp;
    logic              s_arvalid, s_arready = 1'b0;
    logic [3:0]        s_arid;
    logic [31:0]       s_araddr;
    logic [2:0]        s_arsize;
    logic [7:0]        s_arlen;
    logic [1:0]        s_arburst;
    logic              s_rvalid = 1'b0, s_rready;
    logic [3:0]        s_rid = '0;
    logic [31:0]       s_rdata = '0;
    logic [1:0]        s_rresp = '0;
    logic              s_rlast = 1'b1;
    logic              s_awvalid, s_awready = 1'b0;
    logic [3:0]        s_awid;
    logic [31:0]       s_awaddr;
    logic [2:0]        s_awsize;
    logic [7:0]        s_awlen;
    logic              s_wvalid, s_wready = 1'b0;
    logic [31:0]       s_wdata;
    logic [3:0]        s_wstrb;
    logic              s_wlast;
    logic              s_bvalid = 1'b0, s_bready;
    logic [3:0]        s_bid = '0;
    logic [1:0]        s_bresp = '0;

    int tests = 0;
    int fails = 0;

    scr1_axi_mem_arb dut (
        .clk(clk), .rst_n(rst_n),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_arid(m_arid), .m_araddr(m_araddr), .m_arsize(m_arsize),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awsize(m_awsize),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bid(m_bid), .m_bresp(m_bresp),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_arid(s_arid), .s_araddr(s_araddr), .s_arsize(s_arsize),
        .s_arlen(s_arlen), .s_arburst(s_arburst),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awsize(s_awsize),
        .s_awlen(s_awlen),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bid(s_bid), .s_bresp(s_bresp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to 1ns after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset state
        step();
        #1;
        chk("rst_arready", m_arready, 2'b00);
        chk("rst_awready", m_awready, 2'b00);
        chk("rst_s_arvalid", s_arvalid, 1'b0);
        chk("rst_s_awvalid", s_awvalid, 1'b0);
        chk("rst_s_araddr", s_araddr, 32'h0);
        chk("rst_fixed", {s_arlen, s_arburst, s_awlen, s_wlast}, {8'd0, 2'b01, 8'd0, 1'b1});
        step();
        rst_n = 1'b1;

        // Single-master read
        m_arvalid = 2'b01; m_arid[0] = 4'd3; m_araddr[0] = 32'h100; m_arsize[0] = 3'd2;
        #1;
        chk("rd1_arready_c0", m_arready, 2'b01);
        chk("rd1_s_arvalid_c0", s_arvalid, 1'b0);
        step();
        m_arvalid = 2'b00;
        #1;
        chk("rd1_s_arvalid_c1", s_arvalid, 1'b1);
        chk("rd1_s_ar_payload", {s_arid, s_araddr, s_arsize}, {4'd3, 32'h100, 3'd2});
        s_arready = 1'b1;
        step();
        s_arready = 1'b0; s_rvalid = 1'b1; s_rdata = 32'hDEADBEEF; s_rid = 4'd3; m_rready = 2'b01;
        #1;
        chk("rd1_m_rvalid", m_rvalid, 2'b01);
        chk("rd1_m_rdata0", m_rdata[0], 32'hDEADBEEF);
        chk("rd1_m_rid0", m_rid[0], 4'd3);
        chk("rd1_s_rready", s_rready, 1'b1);
        step();
        #1;
        chk("rd1_done_rvalid", m_rvalid, 2'b00);
        s_rvalid = 1'b0; m_rready = 2'b00;

        // Contention from reset: grants alternate 0,1,0,1
        do_reset();
        m_arvalid = 2'b11; m_arid[0] = 4'd1; m_arid[1] = 4'd2;
        m_araddr[0] = 32'h10; m_araddr[1] = 32'h20;
        for (int i = 0; i < 4; i++) begin
            int g;
            logic [3:0] id_g;
            g = i % 2;
            id_g = (g == 0) ? 4'd1 : 4'd2;
            s_rvalid = 1'b0;
            #1;
            chk($sformatf("rr%0d_arready", i), m_arready, 2'b01 << g);
            step();
            #1;
            chk($sformatf("rr%0d_s_arid", i), s_arid, id_g);
            s_arready = 1'b1;
            step();
            s_arready = 1'b0; s_rvalid = 1'b1; s_rid = id_g; s_rdata = 32'hA0 + 32'(i); m_rready = 2'b11;
            #1;
            chk($sformatf("rr%0d_m_rvalid", i), m_rvalid, 2'b01 << g);
            chk($sformatf("rr%0d_m_rid", i), m_rid[g], id_g);
            step();
        end
        s_rvalid = 1'b0; m_arvalid = 2'b00; m_rready = 2'b00;

        // Read-data backpressure for 3 cycles
        m_arvalid = 2'b01; m_arid[0] = 4'd5; m_araddr[0] = 32'h300;
        step();
        m_arvalid = 2'b00; s_arready = 1'b1;
        step();
        s_arready = 1'b0; s_rvalid = 1'b1; s_rid = 4'd5; s_rdata = 32'h55;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("bp%0d_s_rready", i), s_rready, 1'b0);
            chk($sformatf("bp%0d_m_rvalid", i), m_rvalid, 2'b01);
            step();
        end
        m_rready = 2'b01;
        #1;
        chk("bp_release_s_rready", s_rready, 1'b1);
        step();
        #1;
        chk("bp_done_m_rvalid", m_rvalid, 2'b00);
        s_rvalid = 1'b0; m_rready = 2'b00;

        // Write from m1 with data arriving late
        m_awvalid = 2'b10; m_awid[1] = 4'd6; m_awaddr[1] = 32'h200; m_awsize[1] = 3'd2;
        #1;
        chk("wr_awready_c0", m_awready, 2'b10);
        step();
        m_awvalid = 2'b00;
        #1;
        chk("wr_s_awvalid_c1", s_awvalid, 1'b1);
        chk("wr_s_aw_payload", {s_awid, s_awaddr, s_awsize}, {4'd6, 32'h200, 3'd2});
        chk("wr_s_wvalid_c1", s_wvalid, 1'b0);
        s_awready = 1'b1; s_wready = 1'b1;
        step();
        s_awready = 1'b0;
        #1;
        chk("wr_s_awvalid_c2", s_awvalid, 1'b0);
        m_wvalid = 2'b10; m_wdata[1] = 32'h12345678; m_wstrb[1] = 4'hF;
        #1;
        chk("wr_s_wvalid_c2", s_wvalid, 1'b1);
        chk("wr_s_w_payload", {s_wdata, s_wstrb}, {32'h12345678, 4'hF});
        chk("wr_m_wready", m_wready, 2'b10);
        step();
        m_wvalid = 2'b00; s_wready = 1'b0;
        s_bvalid = 1'b1; s_bid = 4'd6; s_bresp = 2'd0; m_bready = 2'b10;
        #1;
        chk("wr_m_bvalid", m_bvalid, 2'b10);
        chk("wr_m_b_payload", {m_bid[1], m_bresp[1]}, {4'd6, 2'd0});
        chk("wr_s_bready", s_bready, 1'b1);
        step();
        #1;
        chk("wr_done_m_bvalid", m_bvalid, 2'b00);
        s_bvalid = 1'b0; m_bready = 2'b00;

        // Concurrent read (m0) and write (m1)
        m_arvalid = 2'b01; m_arid[0] = 4'd7; m_araddr[0] = 32'h400;
        m_awvalid = 2'b10; m_awid[1] = 4'd9; m_awaddr[1] = 32'h500;
        #1;
        chk("cc_ready_c0", {m_arready, m_awready}, {2'b01, 2'b10});
        step();
        m_arvalid = 2'b00; m_awvalid = 2'b00;
        #1;
        chk("cc_valid_c1", {s_arvalid, s_awvalid}, 2'b11);
        s_arready = 1'b1; s_awready = 1'b1; m_wvalid = 2'b10; m_wdata[1] = 32'hCAFE; s_wready = 1'b1;
        step();
        s_arready = 1'b0; s_awready = 1'b0; m_wvalid = 2'b00; s_wready = 1'b0;
        s_rvalid = 1'b1; s_rid = 4'd7; m_rready = 2'b01;
        s_bvalid = 1'b1; s_bid = 4'd9; m_bready = 2'b10;
        #1;
        chk("cc_resp_valid", {m_rvalid, m_bvalid}, {2'b01, 2'b10});
        chk("cc_resp_ids", {m_rid[0], m_bid[1]}, {4'd7, 4'd9});
        step();
        #1;
        chk("cc_done", {m_rvalid, m_bvalid}, 4'b0000);
        s_rvalid = 1'b0; s_bvalid = 1'b0; m_rready = 2'b00; m_bready = 2'b00;

        // Reset while in R_DATA, then pointer back at 0
        m_arvalid = 2'b10; m_arid[1] = 4'd4; m_araddr[1] = 32'h600;
        step();
        m_arvalid = 2'b00; s_arready = 1'b1;
        step();
        s_arready = 1'b0; s_rvalid = 1'b1; s_rid = 4'd4;
        #1;
        chk("rs_pre_m_rvalid", m_rvalid, 2'b10);
        step();
        m_arvalid = 2'b11; m_arid[0] = 4'd8; m_arid[1] = 4'd4;
        rst_n = 1'b0;
        #1;
        chk("rs_outputs_zero", {m_rvalid, m_arready, s_arvalid, s_rready, s_araddr}, 38'h0);
        s_rvalid = 1'b0;
        step();
        rst_n = 1'b1;
        #1;
        chk("rs_grant_m0", m_arready, 2'b01);
        step();
        #1;
        chk("rs_s_arid", s_arid, 4'd8);
        m_arvalid = 2'b00;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Hard stop in case the directed sequence ever stalls.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
